// File: rtl/bullet_pkg.sv
// Shared constants, FSM state type and velocity table
// for the bullet pool controller.
package bullet_pkg;

   localparam int ANGLE_AMOUNT = 16;
   localparam int B_SIZE       = 36;
   localparam int SCREEN_W     = 640;
   localparam int SCREEN_H     = 480;
   localparam int X_MAX        = SCREEN_W - B_SIZE;
   localparam int Y_MAX        = SCREEN_H - B_SIZE;

   typedef enum logic {
      IDLE,
      UPDATE
   } state_t;

   // speed-4 step per 22.5 degrees; screen y grows downward
   function automatic logic signed [4:0] dx_of(input logic [3:0] a);
      case (a)
         4'd0:    dx_of = 5'sd4;
         4'd1:    dx_of = 5'sd4;
         4'd2:    dx_of = 5'sd3;
         4'd3:    dx_of = 5'sd2;
         4'd4:    dx_of = 5'sd0;
         4'd5:    dx_of = -5'sd2;
         4'd6:    dx_of = -5'sd3;
         4'd7:    dx_of = -5'sd4;
         4'd8:    dx_of = -5'sd4;
         4'd9:    dx_of = -5'sd4;
         4'd10:   dx_of = -5'sd3;
         4'd11:   dx_of = -5'sd2;
         4'd12:   dx_of = 5'sd0;
         4'd13:   dx_of = 5'sd2;
         4'd14:   dx_of = 5'sd3;
         default: dx_of = 5'sd4;
      endcase
   endfunction

   function automatic logic signed [4:0] dy_of(input logic [3:0] a);
      case (a)
         4'd0:    dy_of = 5'sd0;
         4'd1:    dy_of = -5'sd2;
         4'd2:    dy_of = -5'sd3;
         4'd3:    dy_of = -5'sd4;
         4'd4:    dy_of = -5'sd4;
         4'd5:    dy_of = -5'sd4;
         4'd6:    dy_of = -5'sd3;
         4'd7:    dy_of = -5'sd2;
         4'd8:    dy_of = 5'sd0;
         4'd9:    dy_of = 5'sd2;
         4'd10:   dy_of = 5'sd3;
         4'd11:   dy_of = 5'sd4;
         4'd12:   dy_of = 5'sd4;
         4'd13:   dy_of = 5'sd4;
         4'd14:   dy_of = 5'sd3;
         default: dy_of = 5'sd2;
      endcase
   endfunction

endpackage

// File: rtl/bullet_pool_ctrl_if.sv
// Fire request channel between shooters (master)
// and the bullet pool (slave).
interface bullet_pool_ctrl_if #(
   parameter int N_REQ = 4
);

   logic [N_REQ-1:0]    fire_req;
   logic [10*N_REQ-1:0] fire_x;
   logic [10*N_REQ-1:0] fire_y;
   logic [4*N_REQ-1:0]  fire_angle;
   logic [4*N_REQ-1:0]  fire_type;
   logic [N_REQ-1:0]    fire_ack;
   logic [N_REQ-1:0]    fire_drop;

   modport master (
      output fire_req, fire_x, fire_y, fire_angle, fire_type,
      input  fire_ack, fire_drop
   );

   modport slave (
      input  fire_req, fire_x, fire_y, fire_angle, fire_type,
      output fire_ack, fire_drop
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; search starts
// at ptr, the pointer register lives in the parent.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PW-1:0]    ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [PW-1:0]    gnt_idx
);

   // walk backwards so the requester nearest ptr is kept last
   always_comb begin
      int j;
      j       = 0;
      gnt     = '0;
      gnt_idx = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         j = int'(ptr) + k;
         if (j >= N_REQ) j = j - N_REQ;
         if (req[j]) begin
            gnt     = '0;
            gnt[j]  = 1'b1;
            gnt_idx = PW'(j);
         end
      end
   end

endmodule

// File: rtl/bullet_pool_ctrl.sv
// Bullet slot pool: round-robin fire allocation into the
// lowest free slot, per-frame motion sweep and retirement.
module bullet_pool_ctrl #(
   parameter int N_BULLETS = 20,
   parameter int N_REQ     = 4,
   parameter int SCREEN_W  = bullet_pkg::SCREEN_W,
   parameter int SCREEN_H  = bullet_pkg::SCREEN_H,
   parameter int B_SIZE    = bullet_pkg::B_SIZE,
   parameter int IDX_W     = 5
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    frame_tick,
   bullet_pool_ctrl_if.slave       fire,
   input  logic [N_BULLETS-1:0]    hit_clear,
   output logic [N_BULLETS-1:0]    bullet_active,
   output logic [10*N_BULLETS-1:0] bullet_x,
   output logic [10*N_BULLETS-1:0] bullet_y,
   output logic [4*N_BULLETS-1:0]  bullet_angle,
   output logic [4*N_BULLETS-1:0]  bullet_type,
   output logic                    busy
);

   import bullet_pkg::*;

   localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int XLIM = SCREEN_W - B_SIZE;
   localparam int YLIM = SCREEN_H - B_SIZE;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     idx_q;
   logic                 tick_pend_q;
   logic [PW-1:0]        rr_q;
   logic [N_REQ-1:0]     ack_q, drop_q;
   logic [N_BULLETS-1:0] act_q;
   logic [9:0]           x_q   [N_BULLETS];
   logic [9:0]           y_q   [N_BULLETS];
   logic [3:0]           ang_q [N_BULLETS];
   logic [3:0]           typ_q [N_BULLETS];

   logic [N_REQ-1:0]     req_m, gnt;
   logic [PW-1:0]        gnt_idx;
   logic                 free_ok;
   logic [IDX_W-1:0]     free_idx;
   logic                 go_upd, go_fire, do_slot, last_slot;
   logic signed [4:0]    dx, dy;
   logic signed [10:0]   nx, ny;
   logic                 off;

   // a requester just answered is masked so a held level
   // cannot fire twice before it sees its ack
   assign req_m = fire.fire_req & ~ack_q & ~drop_q;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .PW    (PW)
   ) u_arb (
      .req     (req_m),
      .ptr     (rr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign last_slot = (idx_q == IDX_W'(N_BULLETS - 1));

   // state register
   always_ff @(posedge CLK) begin
      if (RST) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // next-state logic: pending/new tick beats firing
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (frame_tick || tick_pend_q) state_d = UPDATE;
         UPDATE:  if (last_slot) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // per-state control strobes
   always_comb begin
      go_upd  = 1'b0;
      go_fire = 1'b0;
      do_slot = 1'b0;
      busy    = 1'b0;
      unique case (state_q)
         IDLE: begin
            go_upd  = frame_tick | tick_pend_q;
            go_fire = ~go_upd & (|req_m);
         end
         UPDATE: begin
            do_slot = 1'b1;
            busy    = 1'b1;
         end
         default: ;
      endcase
   end

   // lowest inactive slot
   always_comb begin
      free_ok  = 1'b0;
      free_idx = '0;
      for (int i = N_BULLETS - 1; i >= 0; i--) begin
         if (!act_q[i]) begin
            free_ok  = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
   end

   // next position of the swept slot and off-screen test
   always_comb begin
      dx  = dx_of(ang_q[idx_q]);
      dy  = dy_of(ang_q[idx_q]);
      nx  = $signed({1'b0, x_q[idx_q]}) + $signed({{6{dx[4]}}, dx});
      ny  = $signed({1'b0, y_q[idx_q]}) + $signed({{6{dy[4]}}, dy});
      off = (nx < 11'sd0) || (nx > $signed(11'(XLIM))) ||
            (ny < 11'sd0) || (ny > $signed(11'(YLIM)));
   end

   // sweep index, tick merge, rr pointer and ack/drop pulses
   always_ff @(posedge CLK) begin
      if (RST) begin
         idx_q       <= '0;
         tick_pend_q <= 1'b0;
         rr_q        <= '0;
         ack_q       <= '0;
         drop_q      <= '0;
      end else begin
         ack_q  <= '0;
         drop_q <= '0;
         if (go_upd) begin
            idx_q       <= '0;
            tick_pend_q <= 1'b0;
         end else if (do_slot) begin
            idx_q <= idx_q + 1'b1;
            if (frame_tick) tick_pend_q <= 1'b1;
         end
         if (go_fire) begin
            if (free_ok) ack_q  <= gnt;
            else         drop_q <= gnt;
            rr_q <= (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
         end
      end
   end

   // slot storage: allocation beats hit_clear, hit_clear beats sweep
   always_ff @(posedge CLK) begin
      if (RST) begin
         act_q <= '0;
         for (int i = 0; i < N_BULLETS; i++) begin
            x_q[i]   <= '0;
            y_q[i]   <= '0;
            ang_q[i] <= '0;
            typ_q[i] <= '0;
         end
      end else begin
         act_q <= act_q & ~hit_clear;
         if (do_slot && act_q[idx_q] && !hit_clear[idx_q]) begin
            if (off) begin
               act_q[idx_q] <= 1'b0;
            end else begin
               x_q[idx_q] <= nx[9:0];
               y_q[idx_q] <= ny[9:0];
            end
         end
         if (go_fire && free_ok) begin
            act_q[free_idx] <= 1'b1;
            x_q[free_idx]   <= fire.fire_x[int'(gnt_idx)*10 +: 10];
            y_q[free_idx]   <= fire.fire_y[int'(gnt_idx)*10 +: 10];
            ang_q[free_idx] <= fire.fire_angle[int'(gnt_idx)*4 +: 4];
            typ_q[free_idx] <= fire.fire_type[int'(gnt_idx)*4 +: 4];
         end
      end
   end

   assign fire.fire_ack  = ack_q;
   assign fire.fire_drop = drop_q;
   assign bullet_active  = act_q;

   for (genvar i = 0; i < N_BULLETS; i++) begin : g_out
      assign bullet_x[i*10 +: 10]    = x_q[i];
      assign bullet_y[i*10 +: 10]    = y_q[i];
      assign bullet_angle[i*4 +: 4]  = ang_q[i];
      assign bullet_type[i*4 +: 4]   = typ_q[i];
   end

endmodule

// File: tb/tb_bullet_pool_ctrl.sv
// Scoreboard bench for bullet_pool_ctrl: directed fire,
// pool-full, sweep, retirement and tick-merge scenarios.
module tb_bullet_pool_ctrl;

   localparam int NB = 20;
   localparam int NR = 4;

   logic          CLK = 1'b0;
   logic          RST;
   logic          frame_tick;
   logic [NB-1:0] hit_clear;
   logic [NB-1:0] bullet_active;
   logic [10*NB-1:0] bullet_x, bullet_y;
   logic [4*NB-1:0]  bullet_angle, bullet_type;
   logic          busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit is_ack;
      int r;
      int slot;
      int x;
      int y;
      int a;
      int t;
   } exp_t;

   exp_t sbq[$];

   bullet_pool_ctrl_if #(.N_REQ(NR)) fif ();

   bullet_pool_ctrl #(
      .N_BULLETS (NB),
      .N_REQ     (NR)
   ) dut (
      .CLK           (CLK),
      .RST           (RST),
      .frame_tick    (frame_tick),
      .fire          (fif),
      .hit_clear     (hit_clear),
      .bullet_active (bullet_active),
      .bullet_x      (bullet_x),
      .bullet_y      (bullet_y),
      .bullet_angle  (bullet_angle),
      .bullet_type   (bullet_type),
      .busy          (busy)
   );

   always #5 CLK = ~CLK;

   function automatic int bx(int i);
      return int'(bullet_x[i*10 +: 10]);
   endfunction

   function automatic int by(int i);
      return int'(bullet_y[i*10 +: 10]);
   endfunction

   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, act, exp);
      end
   endtask

   // monitor: pop one expectation per ack/drop pulse
   initial begin
      exp_t e;
      int   ea, ed;
      forever begin
         @(negedge CLK);
         if (fif.fire_ack !== '0 || fif.fire_drop !== '0) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_resp got ack=%b drop=%b expected none",
                        fif.fire_ack, fif.fire_drop);
            end else begin
               e  = sbq.pop_front();
               ea = e.is_ack ? (1 << e.r) : 0;
               ed = e.is_ack ? 0 : (1 << e.r);
               chk("ack_vec", int'(fif.fire_ack), ea);
               chk("drop_vec", int'(fif.fire_drop), ed);
               if (e.is_ack) begin
                  chk("slot_active", int'(bullet_active[e.slot]), 1);
                  chk("slot_x", bx(e.slot), e.x);
                  chk("slot_y", by(e.slot), e.y);
                  chk("slot_ang", int'(bullet_angle[e.slot*4 +: 4]), e.a);
                  chk("slot_type", int'(bullet_type[e.slot*4 +: 4]), e.t);
               end
            end
         end
      end
   end

   task automatic do_reset();
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic set_data(int r, int x, int y, int a, int t);
      fif.fire_x[r*10 +: 10]   = 10'(x);
      fif.fire_y[r*10 +: 10]   = 10'(y);
      fif.fire_angle[r*4 +: 4] = 4'(a);
      fif.fire_type[r*4 +: 4]  = 4'(t);
   endtask

   // single requester; expectation pushed with the stimulus
   task automatic fire1(int r, int x, int y, int a, int t,
                        bit ack, int slot);
      exp_t e;
      bit   seen;
      e = '{ack, r, slot, x, y, a, t};
      sbq.push_back(e);
      set_data(r, x, y, a, t);
      fif.fire_req[r] = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge CLK);
         if (fif.fire_ack[r] || fif.fire_drop[r]) seen = 1'b1;
      end
      fif.fire_req[r] = 1'b0;
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL fire_timeout r=%0d got no response expected one", r);
      end
   endtask

   // all four requesters held together, expected order 0..3
   task automatic fire_all(int base);
      exp_t e;
      for (int r = 0; r < NR; r++) begin
         set_data(r, 200 + 40*r + base, 100 + base, r, r % 3);
         e = '{1'b1, r, base + r, 200 + 40*r + base, 100 + base, r, r % 3};
         sbq.push_back(e);
      end
      fif.fire_req = '1;
      for (int i = 0; i < 40 && fif.fire_req != '0; i++) begin
         @(negedge CLK);
         for (int r = 0; r < NR; r++)
            if (fif.fire_ack[r]) fif.fire_req[r] = 1'b0;
      end
      if (fif.fire_req != '0) begin
         checks++;
         errors++;
         $display("FAIL fire_all_timeout got req=%b expected 0000", fif.fire_req);
         fif.fire_req = '0;
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60 && busy; i++) @(negedge CLK);
   endtask

   initial begin
      int cyc, rises;
      bit prev;
      RST            = 1'b1;
      frame_tick     = 1'b0;
      hit_clear      = '0;
      fif.fire_req   = '0;
      fif.fire_x     = '0;
      fif.fire_y     = '0;
      fif.fire_angle = '0;
      fif.fire_type  = '0;

      do_reset();
      chk("rst_active", int'(bullet_active), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ack", int'(fif.fire_ack), 0);
      chk("rst_drop", int'(fif.fire_drop), 0);
      chk("rst_x_zero", int'(bullet_x == '0), 1);

      fire1(0, 100, 200, 0, 1, 1'b1, 0);
      chk("single_only_slot0", int'(bullet_active), 1);

      do_reset();
      fire_all(0);
      fire_all(4);
      chk("rounds_active", int'(bullet_active), 'hFF);

      for (int k = 0; k < 12; k++)
         fire1(1, 50 + k, 300, 8, 2, 1'b1, 8 + k);
      chk("full_active", int'(bullet_active), 'hFFFFF);
      fire1(2, 500, 400, 3, 0, 1'b0, 0);
      chk("drop_keep_x19", bx(19), 61);
      chk("drop_keep_y19", by(19), 300);
      chk("drop_full", int'(bullet_active), 'hFFFFF);
      hit_clear = NB'(1) << 7;
      @(negedge CLK);
      hit_clear = '0;
      chk("hit7_cleared", int'(bullet_active[7]), 0);
      fire1(2, 77, 88, 5, 1, 1'b1, 7);

      do_reset();
      fire1(0, 100, 200, 0, 1, 1'b1, 0);
      fire1(1, 602, 100, 0, 0, 1'b1, 1);
      fire1(2, 300, 2, 4, 2, 1'b1, 2);
      fire1(3, 300, 300, 12, 1, 1'b1, 3);
      frame_tick = 1'b1;
      cyc = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge CLK);
         frame_tick = 1'b0;
         if (busy) cyc++;
      end
      chk("sweep_len", cyc, 20);
      chk("s0_x", bx(0), 104);
      chk("s0_y", by(0), 200);
      chk("s0_active", int'(bullet_active[0]), 1);
      chk("s1_retired", int'(bullet_active[1]), 0);
      chk("s1_x_kept", bx(1), 602);
      chk("s2_retired", int'(bullet_active[2]), 0);
      chk("s2_y_kept", by(2), 2);
      chk("s3_y", by(3), 304);

      frame_tick = 1'b1;
      cyc   = 0;
      rises = 0;
      prev  = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge CLK);
         frame_tick = (i == 3 || i == 6);
         if (busy) cyc++;
         if (busy && !prev) rises++;
         prev = busy;
      end
      chk("merged_sweeps", rises, 2);
      chk("merged_busy_cyc", cyc, 40);
      chk("s0_x_2sweeps", bx(0), 112);
      chk("s3_y_2sweeps", by(3), 312);

      frame_tick = 1'b1;
      @(negedge CLK);
      frame_tick = 1'b0;
      hit_clear  = NB'(1);
      @(negedge CLK);
      hit_clear  = '0;
      wait_idle();
      chk("hit_sweep_inactive", int'(bullet_active[0]), 0);
      chk("hit_sweep_x", bx(0), 112);
      chk("s3_y_3sweeps", by(3), 316);

      frame_tick = 1'b1;
      @(negedge CLK);
      frame_tick = 1'b0;
      repeat (5) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_active", int'(bullet_active), 0);
      chk("midrst_ack", int'(fif.fire_ack), 0);

      repeat (4) @(negedge CLK);
      chk("sb_empty", sbq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got hang expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/bullet_pool_ctrl.md
Name: bullet_pool_ctrl

Overview:
- Owns the shared pool of N_BULLETS bullet slots that the bullet pixel renderer reads.
- Arbitrates fire requests from several shooters (player, enemies) with round-robin priority and allocates the lowest free slot.
- Advances every active bullet once per frame and retires bullets that leave the screen or are reported hit.
- Sits between the game logic/collision unit and the renderer.

Parameters:
- N_BULLETS, 20: number of bullet slots.
- N_REQ, 4: number of fire requesters.
- SCREEN_W, 640: visible width in pixels.
- SCREEN_H, 480: visible height in pixels.
- B_SIZE, 36: bullet sprite edge in pixels.
- IDX_W, 5: slot index width; must satisfy 2^IDX_W >= N_BULLETS.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per frame (vsync start).
- fire_req  in  N_REQ  level request per shooter; held until fire_ack or fire_drop.
- fire_x  in  10*N_REQ  spawn top-left x per requester.
- fire_y  in  10*N_REQ  spawn top-left y per requester.
- fire_angle  in  4*N_REQ  spawn angle, in 22.5-degree steps.
- fire_type  in  4*N_REQ  sprite type, 0..2.
- hit_clear  in  N_BULLETS  one-cycle pulse per slot; deactivates that slot.
- fire_ack  out  N_REQ  one-cycle pulse: request accepted.
- fire_drop  out  N_REQ  one-cycle pulse: pool full, request discarded.
- bullet_active  out  N_BULLETS  slot valid.
- bullet_x  out  10*N_BULLETS  per-slot top-left x.
- bullet_y  out  10*N_BULLETS  per-slot top-left y.
- bullet_angle  out  4*N_BULLETS  per-slot angle.
- bullet_type  out  4*N_BULLETS  per-slot type.
- busy  out  1  high while the UPDATE sweep runs.

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE. Round-robin pointer = 0. tick_pending = 0. The one-cycle RST check is synchronous.
- States: IDLE, UPDATE.
- IDLE, frame_tick or tick_pending high: go to UPDATE with sweep index = 0, clear tick_pending. This takes priority over fire handling in the same cycle.
- IDLE, otherwise, any fire_req high:
  - The arbiter grants one requester, starting the search at the RR pointer.
  - If a free slot exists, the lowest free slot is written with x, y, angle, type and active = 1; fire_ack[g] pulses on the next cycle edge (registered).
  - If no slot is free, fire_drop[g] pulses instead.
  - Either way the RR pointer becomes g+1 mod N_REQ.
  - Throughput: one request per cycle.
- UPDATE: one slot per cycle, index 0..N_BULLETS-1; go to IDLE after the last slot. Sweep length = N_BULLETS cycles. busy = 1 throughout. fire_req is not serviced during UPDATE.
- Slot update, active slots only:
  - nx = x + DX[angle], ny = y + DY[angle]. DX/DY are signed 5-bit values (speed 4) from the package table.
  - Compute in 11-bit signed arithmetic.
  - If nx < 0, nx > SCREEN_W-B_SIZE, ny < 0 or ny > SCREEN_H-B_SIZE: active <= 0 and x/y are left unchanged. Otherwise x <= nx, y <= ny.
- frame_tick during UPDATE sets tick_pending. Further ticks while pending are merged and do not queue.
- hit_clear[i]: active[i] <= 0 on the next edge in any state.
  - If slot i is being swept in the same cycle, the clear wins.
  - A hit_clear on a slot being allocated in the same cycle is ignored, since the slot was free.
- Free-slot search is combinational: a priority encoder over ~bullet_active.
- Outputs are registered. Renderer-visible state changes at most one slot per cycle.
- RST mid-sweep: returns to IDLE, all slots inactive, and no ack/drop is emitted.

Decomposition:
- Shared package bullet_pkg holds:
  - ANGLE_AMOUNT = 16 and B_SIZE.
  - The 16-entry signed DX/DY velocity LUT.
  - Screen limits.
  - The state enum {IDLE, UPDATE}.
- Sub-module rr_arbiter (parameter N_REQ): inputs req and a pointer; outputs the one-hot grant and the grant index. It is combinational; the pointer register stays in the parent.

Test Plan:
- Reset, then single fire_req[0] with x=100, y=200, angle=0, type=1 → fire_ack[0] pulse; slot 0 active with x=100, y=200, type=1; all other slots inactive.
- fire_req = 4'b1111 held in IDLE → acks in order 0,1,2,3 on consecutive cycles, filling slots 0..3. A second round starts from the pointer, giving order 0,1,2,3 again.
- 20 slots full plus fire_req[2] → fire_drop[2] pulse and no slot is overwritten. Then hit_clear[7] followed by fire_req[2] → slot 7 is allocated.
- Slot 0 at x=100, angle 0 (DX=+4, DY=0), frame_tick → busy for 20 cycles; x becomes 104 and y is unchanged.
- Slot at x=602, angle 0, frame_tick → nx=606 > 604, so the slot is retired (active=0). A slot at y=2 with DY=-4 is also retired.
- frame_tick issued twice during UPDATE → exactly one extra sweep follows. hit_clear on the slot under sweep → the slot ends inactive with x unchanged.
